// File: rtl/memy_stream_loader.sv
// Streams one frame of samples into memory Y, then starts the coprocessor on it; writes land one cycle after acceptance.
// s_ready drops from the final beat until the coprocessor reports done; overlong frames are drained without writes and flagged.
module memy_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  memY_wr_en,
    output logic [ADDR_WIDTH-1:0] memY_wr_addr,
    output logic [DATA_WIDTH-1:0] memY_wr_data,
    output logic [ADDR_WIDTH-1:0] sizeY,
    output logic                  start,
    input  logic                  busy,
    input  logic                  done,
    output logic                  frame_err
);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, ARM, WAIT_DONE} state_t;

    // Address of the last beat that fits: 2^ADDR_WIDTH-2 (the frame holds 2^ADDR_WIDTH-1 beats).
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    state_t                state;
    state_t                stateNext;
    logic                  rdyEn;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  accept;
    logic                  armed;

    assign s_ready = rdyEn && (state == IDLE || state == LOAD || state == DRAIN);
    assign accept  = s_valid && s_ready;
    // ARM is entered with the final write still in flight; start waits until that write has landed.
    assign armed   = (state == ARM) && !memY_wr_en;
    assign start   = armed;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            rdyEn <= 1'b0;
        end else begin
            state <= stateNext;
            rdyEn <= 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) stateNext = s_last ? ARM : LOAD;
            end
            LOAD: begin
                if (accept) begin
                    if (s_last)                 stateNext = ARM;
                    else if (cnt == LAST_ADDR)  stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && s_last) stateNext = IDLE;
            end
            ARM: begin
                if (armed) begin
                    if (done)      stateNext = IDLE;
                    else if (busy) stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt          <= '0;
            memY_wr_en   <= 1'b0;
            memY_wr_addr <= '0;
            memY_wr_data <= '0;
            sizeY        <= '0;
            frame_err    <= 1'b0;
        end else begin
            memY_wr_en <= 1'b0;
            if (accept && state == IDLE) begin
                memY_wr_en   <= 1'b1;
                memY_wr_addr <= '0;
                memY_wr_data <= s_data;
                cnt          <= ADDR_WIDTH'(1);
                frame_err    <= 1'b0;
                if (s_last) sizeY <= ADDR_WIDTH'(1);
            end else if (accept && state == LOAD) begin
                memY_wr_en   <= 1'b1;
                memY_wr_addr <= cnt;
                memY_wr_data <= s_data;
                cnt          <= cnt + 1'b1;
                if (s_last)                sizeY     <= cnt + 1'b1;
                else if (cnt == LAST_ADDR) frame_err <= 1'b1;
            end
        end
    end

endmodule
